// File: rtl/emparejado_if.sv
// Sock pairing station bus: sock delivery and box pickup from the line,
// pairing status back to it.
interface emparejado_if;
    logic       PH;
    logic [1:0] PLS;
    logic [2:0] T;
    logic       BACK;
    logic       RDY;
    logic       PAR;
    logic       REJ;
    logic       ERR;
    logic       CJ;
    logic [3:0] CNT;
    logic [7:0] NBOX;

    modport master (
        output PH, PLS, T, BACK,
        input  RDY, PAR, REJ, ERR, CJ, CNT, NBOX
    );

    modport slave (
        input  PH, PLS, T, BACK,
        output RDY, PAR, REJ, ERR, CJ, CNT, NBOX
    );
endinterface

// File: rtl/emparejado.sv
// Sock pairing station: pairs identical socks, fills boxes of PAIRS_PER_BOX
// pairs and waits for packaging to take each full box.
module emparejado #(
    parameter int unsigned PAIRS_PER_BOX = 6
) (
    input logic        clk,
    input logic        reset,
    emparejado_if.slave bus
);
    localparam logic [1:0] VACIO = 2'd0;
    localparam logic [1:0] UNO   = 2'd1;
    localparam logic [1:0] CAJA  = 2'd2;

    localparam logic [3:0] FULL = 4'(PAIRS_PER_BOX);

    logic [1:0] state;
    logic [1:0] pls_q;
    logic [2:0] t_q;
    logic [3:0] cnt;
    logic [7:0] nbox;
    logic       rdy, cj, par, rej, err;
    logic       valid, match;
    logic [3:0] cnt_inc;

    always_comb begin
        valid = 1'b0;
        unique case ({bus.PLS, bus.T})
            5'b01_001, 5'b10_001, 5'b01_010, 5'b01_100, 5'b10_100: valid = 1'b1;
            default: valid = 1'b0;
        endcase
        match   = (bus.PLS == pls_q) && (bus.T == t_q);
        cnt_inc = cnt + 4'd1;
    end

    // rdy/cj are loaded with the value implied by the next state so they
    // change in the same cycle as the state itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= VACIO;
            pls_q <= '0;
            t_q   <= '0;
            cnt   <= '0;
            nbox  <= '0;
            rdy   <= 1'b1;
            cj    <= 1'b0;
            par   <= 1'b0;
            rej   <= 1'b0;
            err   <= 1'b0;
        end else begin
            par <= 1'b0;
            rej <= 1'b0;
            err <= 1'b0;
            case (state)
                VACIO: begin
                    if (bus.PH) begin
                        if (valid) begin
                            pls_q <= bus.PLS;
                            t_q   <= bus.T;
                            state <= UNO;
                        end else begin
                            rej <= 1'b1;
                        end
                    end
                end
                UNO: begin
                    if (bus.PH) begin
                        if (!valid) begin
                            rej <= 1'b1;
                        end else if (match) begin
                            par <= 1'b1;
                            cnt <= cnt_inc;
                            if (cnt_inc == FULL) begin
                                state <= CAJA;
                                cj    <= 1'b1;
                                rdy   <= 1'b0;
                                nbox  <= nbox + 8'd1;
                            end else begin
                                state <= VACIO;
                            end
                        end else begin
                            rej   <= 1'b1;
                            pls_q <= bus.PLS;
                            t_q   <= bus.T;
                        end
                    end
                end
                CAJA: begin
                    if (bus.PH) err <= 1'b1;
                    if (bus.BACK) begin
                        state <= VACIO;
                        cj    <= 1'b0;
                        rdy   <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= VACIO;
                    cj    <= 1'b0;
                    rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.RDY  = rdy;
    assign bus.PAR  = par;
    assign bus.REJ  = rej;
    assign bus.ERR  = err;
    assign bus.CJ   = cj;
    assign bus.CNT  = cnt;
    assign bus.NBOX = nbox;
endmodule

// File: doc/emparejado.md
EMPAREJADO -- requirements
Module: emparejado

Interface
REQ-001 The module SHALL have parameter PAIRS_PER_BOX, default 6, giving the number of pairs per box (legal range 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port PH, input, 1 bit: one-cycle pulse from the shaping stage meaning one shaped sock is delivered.
REQ-005 The module SHALL have port PLS, input, 2 bits: sock model code, valid in the PH cycle.
REQ-006 The module SHALL have port T, input, 3 bits: one-hot sock size code, valid in the PH cycle.
REQ-007 The module SHALL have port BACK, input, 1 bit: box-taken acknowledge from packaging.
REQ-008 The module SHALL have port RDY, output, 1 bit: pairing station can accept a sock.
REQ-009 The module SHALL have port PAR, output, 1 bit: one-cycle pulse meaning a pair was formed.
REQ-010 The module SHALL have port REJ, output, 1 bit: one-cycle pulse meaning a sock was rejected.
REQ-011 The module SHALL have port ERR, output, 1 bit: one-cycle pulse meaning a sock arrived while RDY=0 and was lost.
REQ-012 The module SHALL have port CJ, output, 1 bit: level meaning a full box is waiting for pickup.
REQ-013 The module SHALL have port CNT, output, 4 bits: pairs in the current box.
REQ-014 The module SHALL have port NBOX, output, 8 bits: boxes completed, wrapping modulo 256.

Function
REQ-015 The state machine SHALL have exactly three states: VACIO (no sock held), UNO (one sock held, with its PLS/T latched) and CAJA (box full).
REQ-016 A sock code SHALL be valid only for these PLS/T combinations: 01/001, 10/001, 01/010, 01/100, 10/100; every other combination SHALL be invalid.
REQ-017 In VACIO or UNO, PH with an invalid code SHALL assert REJ in the next cycle and change no state, latch or counter.
REQ-018 In VACIO, PH with a valid code SHALL latch PLS/T and move to UNO in the next cycle.
REQ-019 In UNO, PH with a valid code equal to the latched PLS and T SHALL assert PAR in the next cycle and increment CNT.
REQ-020 After a pair is formed, the machine SHALL enter CAJA if the new CNT equals PAIRS_PER_BOX, and enter VACIO otherwise.
REQ-021 In UNO, PH with a valid but different code SHALL assert REJ in the next cycle, latch the new sock in place of the held one, and stay in UNO.
REQ-022 On entry to CAJA, CJ SHALL assert in the same cycle as the final PAR and NBOX SHALL increment by 1.
REQ-023 In CAJA, CJ SHALL stay high and CNT SHALL hold PAIRS_PER_BOX until BACK=1 is sampled.
REQ-024 When BACK=1 is sampled in CAJA, the next cycle SHALL have CJ=0, CNT=0 and state VACIO.
REQ-025 BACK SHALL be ignored outside CAJA.
REQ-026 RDY SHALL be 1 in VACIO and UNO and 0 in CAJA, as a registered function of the state.
REQ-027 PH in CAJA SHALL assert ERR in the next cycle and leave the state unchanged, including when BACK=1 in the same cycle (that sock is lost; the BACK exit still happens).
REQ-028 PAR, REJ and ERR SHALL be mutually exclusive, registered, one-cycle-wide pulses.
REQ-029 Latency from an accepted PH to PAR or REJ SHALL be exactly 1 cycle.
REQ-030 PH on consecutive cycles SHALL each be processed with no gap.
REQ-031 When NBOX is 255 and a box completes, NBOX SHALL wrap to 0.

Reset
REQ-032 When reset=1 is sampled on a rising clk edge, the next cycle SHALL have state VACIO, the latch cleared, CNT=0, NBOX=0, CJ=0, PAR=REJ=ERR=0 and RDY=1.
REQ-033 Reset SHALL take priority over PH and BACK in the same cycle.
REQ-034 Reset mid-operation, including in UNO or CAJA, SHALL discard the held sock and the partial box.

Verification
REQ-035 Pair match: PH(01/001), then PH(01/001) -> PAR=1 one cycle after the second PH, CNT=1, state VACIO.
REQ-036 Mismatch: PH(01/001), then PH(10/100) -> REJ=1 one cycle after the second PH, state UNO, latch=10/100; then PH(10/100) -> PAR=1, CNT=1.
REQ-037 Invalid code: PH with PLS=11, T=001 in VACIO -> REJ=1 one cycle later, CNT and state unchanged.
REQ-038 Full box: 6 matched pairs -> CJ=1, RDY=0, NBOX=1, CNT=6; a PH then -> ERR=1; BACK=1 -> next cycle CJ=0, CNT=0, RDY=1.
REQ-039 Wrap: 256 completed boxes -> NBOX=0.
REQ-040 Reset in UNO with CNT=3 -> next cycle CNT=0, state VACIO; a single subsequent PH produces no PAR.
